// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
// Holds the reader state encoding and counter sizing.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

    // Bits needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rd_stream_buf.sv
// Circular output buffer for the FIFO stream reader.
// Push and pop may happen in the same cycle.
module rd_stream_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int CW         = cnt_width(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         wr_ptr;
    logic [IW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [IW-1:0] ptr_inc(
        input logic [IW-1:0] p
    );
        return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since count gates head.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side FIFO consumer feeding a valid/ready stream.
// Issues credit-checked reads and tracks them through the read latency.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_RD_LAT = 1,
    parameter int BUF_DEPTH   = FIFO_RD_LAT + 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_in,
    input  logic                  areset_b,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty_ind,
    input  logic                  fifo_threshold_ind,
    output logic                  trans_read,
    input  logic                  burst_en,
    input  logic                  flush_req,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  flush_done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int CW = cnt_width(BUF_DEPTH);

    rd_state_e              state;
    rd_state_e              state_nxt;
    logic [FIFO_RD_LAT-1:0] pipe;
    logic [CW-1:0]          inflight;
    logic [CW-1:0]          buf_count;
    logic [CW:0]            credit_used;
    logic                   buf_empty;
    logic                   buf_full;
    logic                   push;
    logic                   pop;
    logic                   drain_go;

    assign credit_used = {1'b0, inflight} + {1'b0, buf_count};
    assign trans_read  = (state != IDLE) && !fifo_empty_ind
                      && !buf_full
                      && (credit_used < (CW+1)'(BUF_DEPTH));
    assign push        = pipe[FIFO_RD_LAT-1];
    assign m_valid     = !buf_empty;
    assign pop         = m_valid && m_ready;
    assign busy        = (state != IDLE) || (inflight != '0)
                      || !buf_empty;
    assign drain_go    = burst_en ? fifo_threshold_ind
                                  : !fifo_empty_ind;

    // Count outstanding reads still travelling through the latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < FIFO_RD_LAT; i++) begin
            inflight = inflight + CW'(pipe[i]);
        end
    end

    // State register, read-latency pipe and delivered-beat counter.
    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            state    <= IDLE;
            pipe     <= '0;
            rd_count <= '0;
        end else begin
            state <= state_nxt;
            pipe  <= FIFO_RD_LAT'({pipe, trans_read});
            if (pop) begin
                rd_count <= rd_count + 1'b1;
            end
        end
    end

    // Next-state and flush completion pulse.
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else if (drain_go) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else if (fifo_empty_ind && !trans_read) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (fifo_empty_ind && inflight == '0 && buf_empty) begin
                    state_nxt  = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    rd_stream_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH),
        .CW         (CW)
    ) u_buf (
        .clk_in    (clk_in),
        .areset_b  (areset_b),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (pop),
        .count     (buf_count),
        .head      (m_data),
        .full      (buf_full),
        .empty     (buf_empty)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a queue-based FIFO model.
// Scoreboard checks order, stall stability and the credit bound.
module tb_fifo_stream_reader;

    localparam int DW     = 32;
    localparam int DEPTH  = 3;
    localparam int THRESH = 2;

    logic          clk_in = 1'b0;
    logic          areset_b;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_empty_ind;
    logic          fifo_threshold_ind;
    logic          trans_read;
    logic          burst_en;
    logic          flush_req;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          flush_done;
    logic          busy;
    logic [15:0]   rd_count;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;
    int rd_iss;
    int beat_cnt;
    logic stall_prev;
    logic [DW-1:0] hold_d;

    always #5 clk_in = ~clk_in;

    fifo_stream_reader dut (
        .clk_in             (clk_in),
        .areset_b           (areset_b),
        .fifo_data_out      (fifo_data_out),
        .fifo_empty_ind     (fifo_empty_ind),
        .fifo_threshold_ind (fifo_threshold_ind),
        .trans_read         (trans_read),
        .burst_en           (burst_en),
        .flush_req          (flush_req),
        .m_valid            (m_valid),
        .m_ready            (m_ready),
        .m_data             (m_data),
        .flush_done         (flush_done),
        .busy               (busy),
        .rd_count           (rd_count)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // FIFO memory model: read latency of one cycle, writes land at edges.
    always @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            fq.delete();
            pend_q.delete();
            fifo_empty_ind     <= 1'b1;
            fifo_threshold_ind <= 1'b0;
            fifo_data_out      <= '0;
        end else begin
            if (trans_read === 1'b1 && fq.size() > 0) begin
                fifo_data_out <= fq.pop_front();
            end
            while (pend_q.size() > 0) begin
                fq.push_back(pend_q.pop_front());
            end
            fifo_empty_ind     <= (fq.size() == 0);
            fifo_threshold_ind <= (fq.size() >= THRESH);
        end
    end

    // Scoreboard: order, stall hold, underflow and credit bound.
    always @(negedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            rd_iss     = 0;
            beat_cnt   = 0;
            stall_prev = 1'b0;
            hold_d     = '0;
        end else begin
            chk("credit", (rd_iss - beat_cnt) <= DEPTH, 1);
            if (trans_read) begin
                chk("underflow", fifo_empty_ind, 0);
                rd_iss++;
            end
            if (stall_prev) begin
                chk("hold", m_data, hold_d);
            end
            stall_prev = m_valid && !m_ready;
            hold_d     = m_data;
            if (m_valid && m_ready) begin
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("data", m_data, exp_q.pop_front());
                end
                beat_cnt++;
            end
        end
    end

    task automatic preload(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            pend_q.push_back(base + DW'(i));
            exp_q.push_back(base + DW'(i));
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int n = 0;
        while ((busy || !fifo_empty_ind || pend_q.size() != 0)
               && n < lim) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_tr, n_mv, f_tr, l_tr, f_mv, l_mv, nfd, fd_k;
        logic [DW-1:0] mv_data;
        logic [15:0] c0;
        logic fd_mv, after_busy;

        areset_b  = 1'b1;
        burst_en  = 1'b0;
        flush_req = 1'b0;
        m_ready   = 1'b0;
        #2 areset_b = 1'b0;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_read", trans_read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", rd_count, 0);
        chk("rst_fdone", flush_done, 0);
        chk("rst_data", m_data, 0);
        repeat (3) @(posedge clk_in);
        #1 areset_b = 1'b1;
        m_ready = 1'b1;
        @(posedge clk_in);
        #1;

        // Single word latency.
        preload(1, 32'hA5A50001);
        n_tr = 0; f_tr = -1; f_mv = -1; mv_data = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (trans_read) begin
                n_tr++;
                if (f_tr < 0) f_tr = k;
            end
            if (m_valid && f_mv < 0) begin
                f_mv = k;
                mv_data = m_data;
            end
        end
        @(posedge clk_in);
        #1;
        chk("t1_nread", n_tr, 1);
        chk("t1_rdcyc", f_tr, 1);
        chk("t1_mvcyc", f_mv, 3);
        chk("t1_data", mv_data, 32'hA5A50001);
        chk("t1_cnt", rd_count, 1);
        chk("t1_busy", busy, 0);

        // Eight words at full rate.
        c0 = rd_count;
        preload(8, 32'h0);
        n_tr = 0; n_mv = 0; f_tr = -1; l_tr = -1;
        f_mv = -1; l_mv = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (trans_read) begin
                n_tr++;
                if (f_tr < 0) f_tr = k;
                l_tr = k;
            end
            if (m_valid) begin
                n_mv++;
                if (f_mv < 0) f_mv = k;
                l_mv = k;
            end
        end
        @(posedge clk_in);
        #1;
        chk("t2_nread", n_tr, 8);
        chk("t2_rdspan", l_tr - f_tr, 7);
        chk("t2_nvalid", n_mv, 8);
        chk("t2_mvspan", l_mv - f_mv, 7);
        chk("t2_cnt", 16'(rd_count - c0), 8);

        // Backpressure stall.
        m_ready = 1'b0;
        c0 = rd_count;
        preload(8, 32'h10);
        n_tr = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (trans_read) n_tr++;
        end
        chk("t3_nread", n_tr, 3);
        chk("t3_valid", m_valid, 1);
        chk("t3_head", m_data, 32'h10);
        @(posedge clk_in);
        #1 m_ready = 1'b1;
        wait_idle("t3", 100);
        chk("t3_cnt", 16'(rd_count - c0), 8);

        // Burst mode waits for the threshold.
        burst_en = 1'b1;
        c0 = rd_count;
        preload(1, 32'h20);
        n_tr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (trans_read) n_tr++;
        end
        chk("t4_noread", n_tr, 0);
        @(posedge clk_in);
        #1;
        preload(1, 32'h21);
        wait_idle("t4", 50);
        chk("t4_cnt", 16'(rd_count - c0), 2);

        // Flush drains a sub-threshold word.
        c0 = rd_count;
        preload(1, 32'h30);
        repeat (2) @(posedge clk_in);
        #1 flush_req = 1'b1;
        @(posedge clk_in);
        #1 flush_req = 1'b0;
        nfd = 0; fd_k = -10; fd_mv = 1'b1; after_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (k == fd_k + 1) after_busy = busy;
            if (flush_done) begin
                nfd++;
                fd_k = k;
                fd_mv = m_valid;
            end
        end
        @(posedge clk_in);
        #1;
        chk("t5_npulse", nfd, 1);
        chk("t5_mv_at_done", fd_mv, 0);
        chk("t5_busy_after", after_busy, 0);
        chk("t5_cnt", 16'(rd_count - c0), 1);
        chk("t5_left", exp_q.size(), 0);
        burst_en = 1'b0;

        // Reset with words buffered and in flight.
        m_ready = 1'b0;
        preload(8, 32'h40);
        n_tr = 0;
        for (int k = 0; k < 20 && n_tr < 3; k++) begin
            @(negedge clk_in);
            if (trans_read) n_tr++;
        end
        @(posedge clk_in);
        #1 areset_b = 1'b0;
        #1;
        chk("t6_valid", m_valid, 0);
        chk("t6_read", trans_read, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cnt", rd_count, 0);
        chk("t6_fdone", flush_done, 0);
        chk("t6_data", m_data, 0);
        exp_q.delete();
        @(posedge clk_in);
        #1 areset_b = 1'b1;
        m_ready = 1'b1;
        n_mv = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            if (m_valid) n_mv++;
        end
        @(posedge clk_in);
        #1;
        chk("t6_stale", n_mv, 0);
        chk("t6_cnt2", rd_count, 0);
        chk("t6_busy2", busy, 0);

        // Random traffic, backpressure, bursts and flushes.
        for (int i = 0; i < 600; i++) begin
            m_ready   = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 40) == 0);
            if (i % 100 == 0) burst_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                pend_q.push_back(DW'($urandom));
                exp_q.push_back(pend_q[pend_q.size() - 1]);
            end
            @(posedge clk_in);
            #1;
        end
        flush_req = 1'b0;
        burst_en  = 1'b0;
        m_ready   = 1'b1;
        wait_idle("rnd", 300);
        chk("rnd_cnt", rd_count, 16'(beat_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the FIFO memory block.
- Watches `fifo_empty_ind` and `fifo_threshold_ind`, and issues one-cycle `trans_read` requests.
- Captures `fifo_data_out` after a fixed read latency and presents the words in order on a valid/ready stream.
- Supports a burst mode, which waits for the threshold before draining, and an explicit flush.

Parameters:
- DATA_WIDTH, 32, stream and FIFO data width.
- FIFO_RD_LAT, 1, cycles from `trans_read` high until `fifo_data_out` holds that word. Must be ≥1.
- BUF_DEPTH, FIFO_RD_LAT+2, output buffer entries. Must be ≥FIFO_RD_LAT+1; ≥FIFO_RD_LAT+2 gives 1 beat/cycle.
- CNT_WIDTH, 16, width of the delivered-beat counter.

Ports:
- clk_in  input  1  clock.
- areset_b  input  1  reset, asynchronous, active-low.
- fifo_data_out  input  DATA_WIDTH  FIFO read data.
- fifo_empty_ind  input  1  FIFO empty. Reflects all reads completed at prior edges.
- fifo_threshold_ind  input  1  FIFO holds ≥THRESHOLD_VALUE entries.
- trans_read  output  1  FIFO read request, one word per high cycle.
- burst_en  input  1  level: drain only once the threshold is reached.
- flush_req  input  1  pulse: drain the FIFO completely regardless of burst_en.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accepts.
- m_data  output  DATA_WIDTH  stream word.
- flush_done  output  1  one-cycle pulse when a flush completes.
- busy  output  1  state≠IDLE, or inflight≠0, or buffer non-empty.
- rd_count  output  CNT_WIDTH  beats delivered (m_valid&&m_ready), wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset values: all outputs 0, state=IDLE, buffer empty, inflight pipe cleared. Reset mid-operation discards in-flight and buffered words.
- States (registered, 2-bit): IDLE, DRAIN, FLUSH.
  - IDLE→FLUSH: flush_req=1. Takes priority over the DRAIN transition.
  - IDLE→DRAIN: (!burst_en && !fifo_empty_ind) || (burst_en && fifo_threshold_ind).
  - DRAIN→FLUSH: flush_req=1.
  - DRAIN→IDLE: fifo_empty_ind=1 and trans_read=0 in that cycle.
  - FLUSH→IDLE: fifo_empty_ind=1, inflight=0 and buffer empty. flush_done=1 in that same cycle.
  - flush_req in FLUSH is ignored.
- trans_read is combinational and never depends on m_ready:
  - trans_read = (state==DRAIN || state==FLUSH) && !fifo_empty_ind && (inflight + buf_count < BUF_DEPTH).
  - Never asserted in IDLE.
  - At most one read per cycle, so no FIFO underflow is possible.
- Inflight pipe: FIFO_RD_LAT-stage valid shift register.
  - A read issued in cycle t is written into the buffer at the clock edge ending cycle t+FIFO_RD_LAT.
  - inflight = number of set stages.
- Output buffer: circular, BUF_DEPTH entries.
  - m_valid = buffer non-empty; m_data = head entry.
  - Push and pop in the same cycle are both performed.
  - Overflow cannot occur because of the credit check; the bench must assert this.
  - While m_valid=1 && m_ready=0, m_data is held stable.
- Ordering: words leave in exactly FIFO order; no drop, no duplicate.
- Latency: fifo_empty_ind falls in cycle 0 (IDLE, burst_en=0) → trans_read in cycle 1 → m_valid in cycle 1+FIFO_RD_LAT+1 (cycle 3 at default).
- Throughput: with m_ready held high and a non-empty FIFO, one beat per cycle once the pipeline is filled.
- Counter widths: buf_count and inflight are $clog2(BUF_DEPTH+1) bits. rd_count wraps.

Decomposition:
- Package fifo_stream_reader_pkg:
  - state enum rd_state_e {IDLE, DRAIN, FLUSH} as 2-bit logic.
  - localparam function for the counter width.
- Sub-module rd_stream_buf: DATA_WIDTH×BUF_DEPTH circular buffer with push, pop, count, head data, full and empty.
- The FSM, credit logic and inflight pipe live in the top module.

Test Plan:
- burst_en=0, write 0xA5A50001 into an empty FIFO, m_ready=1 → trans_read high exactly 1 cycle; m_valid in cycle 3 after empty falls with m_data=0xA5A50001; rd_count=1; back to IDLE; busy=0.
- 8 words 0x00..0x07 preloaded, m_ready=1 → trans_read high 8 consecutive cycles; m_valid high 8 consecutive cycles; data 0x00..0x07 in order; rd_count=8.
- 8 words, m_ready=0 for 10 cycles then 1 → exactly 3 reads issued and then stall; m_data=0x00 stable while stalled; all 8 words delivered in order afterwards; no overflow assertion fires.
- burst_en=1, THRESHOLD_VALUE=2:
  - push 1 word → no trans_read for 20 cycles.
  - push a 2nd word → threshold_ind rises, DRAIN is entered, both words are delivered.
- burst_en=1, 1 word in the FIFO, pulse flush_req → FLUSH; word delivered; flush_done pulses once, in the cycle the buffer is empty; state IDLE next cycle.
- Assert areset_b low with 2 words buffered and 1 in flight → all outputs 0 immediately; after release, state IDLE; rd_count=0; no stale m_valid.
